// File: rtl/ss_pkg.sv
// Shared types and constants for the serial frame deserializer.
// The counter width is a function because it depends on the instantiating module's DATA_W.
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    function automatic int cnt_width(input int data_w);
        return (data_w > 2) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/ss_bit_collector.sv
// Data-bit collector: direction-selectable shift register, bit counter,
// last-bit flag and running XOR of the collected data bits.
module ss_bit_collector
    import ss_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic              msb_first_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] word_o,
    output logic              last_o,
    output logic              parity_o
);

    localparam int CNT_W = cnt_width(DATA_W);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              xor_q, xor_d;

    // Clear only resets the counter and parity; every data bit of the shift
    // register is overwritten before the word is used.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        xor_d   = xor_q;
        if (clear_i) begin
            cnt_d = '0;
            xor_d = 1'b0;
        end else if (shift_i) begin
            if (msb_first_i) begin
                shift_d = {shift_q[DATA_W-2:0], bit_i};
            end else begin
                shift_d = {bit_i, shift_q[DATA_W-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            xor_d = xor_q ^ bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            xor_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
        end
    end

    assign word_o   = shift_q;
    assign last_o   = (cnt_q == CNT_W'(DATA_W - 1));
    assign parity_o = xor_q;

endmodule

// File: rtl/ss_frame_deser.sv
// Frame deserializer: start bit, DATA_W data bits, optional even parity, stop bit,
// sampled only on bit_en cycles; reports the word plus parity/framing errors.
module ss_frame_deser
    import ss_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ERR_STICKY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              serial_in,
    input  logic              bit_en,
    input  logic              msb_first,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    state_e            state_q;
    logic              order_q;
    logic              perr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              parity_err_q;
    logic              frame_err_q;

    logic [DATA_W-1:0] word;
    logic              last_bit;
    logic              data_xor;
    logic              start_seen;
    logic              clear_bits;
    logic              shift_bit;

    assign start_seen = ena && bit_en && (state_q == IDLE) && (serial_in == START_LEVEL);
    assign clear_bits = !ena || start_seen;
    assign shift_bit  = ena && bit_en && (state_q == DATA);

    ss_bit_collector #(
        .DATA_W (DATA_W)
    ) u_collector (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_bits),
        .shift_i     (shift_bit),
        .msb_first_i (order_q),
        .bit_i       (serial_in),
        .word_o      (word),
        .last_o      (last_bit),
        .parity_o    (data_xor)
    );

    // Pulses default low every cycle; sticky flags only change when a frame ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            order_q      <= 1'b0;
            perr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!ERR_STICKY) begin
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
            end
            if (!ena) begin
                state_q <= IDLE;
            end else if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (serial_in == START_LEVEL) begin
                            state_q <= DATA;
                            order_q <= msb_first;
                        end
                    end
                    DATA: begin
                        if (last_bit) begin
                            state_q <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        perr_q  <= data_xor ^ serial_in;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (serial_in == IDLE_LEVEL) begin
                            data_q       <= word;
                            valid_q      <= 1'b1;
                            parity_err_q <= PARITY_EN && perr_q;
                            frame_err_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ss_frame_deser.sv
// Self-checking bench for ss_frame_deser (DATA_W=8, even parity, pulsed errors):
// a frame-level reference model compared every cycle plus hand-computed pins.
module tb_ss_frame_deser;

    localparam int DATA_W     = 8;
    localparam int FRAME_TAIL = DATA_W + 2;

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              serialIn;
    logic              bitEn;
    logic              msbFirst;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              parityErr;
    logic              frameErr;
    logic              busy;

    int checks     = 0;
    int errors     = 0;
    int validCount = 0;

    ss_frame_deser #(
        .DATA_W     (DATA_W),
        .PARITY_EN  (1'b1),
        .ERR_STICKY (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .serial_in  (serialIn),
        .bit_en     (bitEn),
        .msb_first  (msbFirst),
        .data_out   (dataOut),
        .data_valid (dataValid),
        .parity_err (parityErr),
        .frame_err  (frameErr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: collects the bits after a start bit into a queue and,
    // once a whole frame is in, derives the word and flags arithmetically.
    logic [DATA_W-1:0] mData  = '0;
    logic              mValid = 1'b0;
    logic              mPerr  = 1'b0;
    logic              mFerr  = 1'b0;
    logic              mBusy  = 1'b0;
    bit                inFrame = 1'b0;
    bit                mOrder  = 1'b0;
    bit                bitQ[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mData   = '0;
            mValid  = 1'b0;
            mPerr   = 1'b0;
            mFerr   = 1'b0;
            mBusy   = 1'b0;
            inFrame = 1'b0;
            bitQ.delete();
        end else begin
            mValid = 1'b0;
            mPerr  = 1'b0;
            mFerr  = 1'b0;
            if (!ena) begin
                inFrame = 1'b0;
                bitQ.delete();
            end else if (bitEn) begin
                if (!inFrame) begin
                    if (serialIn == 1'b0) begin
                        inFrame = 1'b1;
                        mOrder  = msbFirst;
                        bitQ.delete();
                    end
                end else begin
                    bitQ.push_back(serialIn);
                    if (bitQ.size() == FRAME_TAIL) begin
                        int word;
                        word = 0;
                        for (int i = 0; i < DATA_W; i++) begin
                            if (bitQ[i]) word += mOrder ? (1 << (DATA_W - 1 - i)) : (1 << i);
                        end
                        if (bitQ[FRAME_TAIL-1]) begin
                            mData  = word[DATA_W-1:0];
                            mValid = 1'b1;
                            mPerr  = (($countones(word) + int'(bitQ[DATA_W])) % 2) != 0;
                        end else begin
                            mFerr = 1'b1;
                        end
                        inFrame = 1'b0;
                    end
                end
            end
            mBusy = inFrame;
        end
    end

    task automatic expectEq(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        expectEq("cmp data_out", 16'(dataOut), 16'(mData));
        expectEq("cmp data_valid", 16'(dataValid), 16'(mValid));
        expectEq("cmp parity_err", 16'(parityErr), 16'(mPerr));
        expectEq("cmp frame_err", 16'(frameErr), 16'(mFerr));
        expectEq("cmp busy", 16'(busy), 16'(mBusy));
    endtask

    initial forever begin
        @(negedge clk);
        checkOutput();
        if (dataValid === 1'b1) validCount++;
    end

    task automatic sendBit(input logic b, input int period);
        serialIn = b;
        bitEn    = 1'b1;
        @(posedge clk); #1;
        if (period > 1) begin
            bitEn = 1'b0;
            repeat (period - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        serialIn = 1'b1;
        bitEn    = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] word, input logic msb, input logic pbit,
                                 input logic stopBit, input int period, input bit flip);
        msbFirst = msb;
        sendBit(1'b0, period);
        if (flip) msbFirst = ~msb;
        for (int i = 0; i < DATA_W; i++) begin
            sendBit(msb ? word[DATA_W-1-i] : word[i], period);
        end
        sendBit(pbit, period);
        sendBit(stopBit, period);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        bitEn    = 1'b0;
        serialIn = 1'b1;
        msbFirst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expectEq("reset data_out", 16'(dataOut), 16'h0000);
        expectEq("reset busy", 16'(busy), 16'h0000);
        expectEq("reset data_valid", 16'(dataValid), 16'h0000);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] LSB-first 0xA5, good parity");
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        expectEq("t1 data_valid", 16'(dataValid), 16'h0001);
        expectEq("t1 data_out", 16'(dataOut), 16'h00A5);
        expectEq("t1 parity_err", 16'(parityErr), 16'h0000);
        expectEq("t1 frame_err", 16'(frameErr), 16'h0000);
        idle(1);
        expectEq("t1 valid width", 16'(dataValid), 16'h0000);

        $display("[TB] MSB-first frames");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        expectEq("t2 data_out A5", 16'(dataOut), 16'h00A5);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        expectEq("t2 data_out 3C", 16'(dataOut), 16'h003C);
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        expectEq("t2 order latched", 16'(dataOut), 16'h0001);
        expectEq("t2 order parity", 16'(parityErr), 16'h0000);

        $display("[TB] parity error");
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        expectEq("t3 data_valid", 16'(dataValid), 16'h0001);
        expectEq("t3 data_out", 16'(dataOut), 16'h00A5);
        expectEq("t3 parity_err", 16'(parityErr), 16'h0001);
        idle(1);
        expectEq("t3 parity pulse", 16'(parityErr), 16'h0000);

        $display("[TB] framing error then recovery");
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        expectEq("t4 frame_err", 16'(frameErr), 16'h0001);
        expectEq("t4 data_valid", 16'(dataValid), 16'h0000);
        expectEq("t4 data_out held", 16'(dataOut), 16'h00A5);
        applyStimulus(8'h0F, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        expectEq("t4 data_out 0F", 16'(dataOut), 16'h000F);
        expectEq("t4 frame_err clear", 16'(frameErr), 16'h0000);

        $display("[TB] sparse bit_en, back-to-back frames");
        idle(2);
        v0 = validCount;
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        expectEq("t5 data_out 81", 16'(dataOut), 16'h0081);
        applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        idle(2);
        expectEq("t5 valid pulses", 16'(validCount - v0), 16'h0002);
        expectEq("t5 data_out 7E", 16'(dataOut), 16'h007E);

        $display("[TB] ena dropped mid-frame");
        v0 = validCount;
        msbFirst = 1'b0;
        sendBit(1'b0, 1);
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1);
        expectEq("t6 busy mid-frame", 16'(busy), 16'h0001);
        ena   = 1'b0;
        bitEn = 1'b0;
        @(posedge clk); #1;
        expectEq("t6 busy after ena", 16'(busy), 16'h0000);
        expectEq("t6 data_out kept", 16'(dataOut), 16'h007E);
        ena = 1'b1;
        idle(4);
        expectEq("t6 no pulses", 16'(validCount - v0), 16'h0000);
        expectEq("t6 no frame_err", 16'(frameErr), 16'h0000);
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        expectEq("t6 recovery 33", 16'(dataOut), 16'h0033);

        $display("[TB] async reset mid-frame");
        sendBit(1'b0, 1);
        for (int i = 0; i < 3; i++) sendBit(1'b0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        expectEq("t6 reset data_out", 16'(dataOut), 16'h0000);
        expectEq("t6 reset busy", 16'(busy), 16'h0000);
        expectEq("t6 reset data_valid", 16'(dataValid), 16'h0000);
        expectEq("t6 reset parity_err", 16'(parityErr), 16'h0000);
        expectEq("t6 reset frame_err", 16'(frameErr), 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        applyStimulus(8'h96, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        expectEq("t6 post-reset 96", 16'(dataOut), 16'h0096);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_frame_deser.md
Name: ss_frame_deser

Overview:
- Downstream consumer of the serial-in/serial-out shift register's output bit stream.
- Frames the stream as start bit, DATA_W data bits, optional even parity bit and stop bit, and reassembles each frame into a parallel word.
- Sampling happens only on cycles qualified by a bit-enable strobe, so the block can run at the shift rate of the upstream register.
- Reports word-valid pulses plus parity and framing errors for the tile's output pins.

Parameters:
DATA_W, 8, number of data bits per frame (2..16)
PARITY_EN, 1, 1 = an even-parity bit follows the data; 0 = no parity bit
ERR_STICKY, 0, 1 = error flags hold until the next valid frame; 0 = error flags pulse for one cycle

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low forces IDLE synchronously
serial_in  input  1  serial bit stream from the upstream shift register
bit_en  input  1  sample strobe; one bit is consumed per cycle with bit_en=1
msb_first  input  1  bit order: 0 = LSB first, 1 = MSB first; captured at the start bit
data_out  output  DATA_W  last completed word; holds until the next good frame
data_valid  output  1  one-cycle pulse when data_out is updated
parity_err  output  1  parity mismatch on the completed frame
frame_err  output  1  stop bit sampled as 0
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; bit counter=0; shift register=0; data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0.
- Line idles high. Only cycles with ena=1 and bit_en=1 sample serial_in. On all other cycles, state and counters hold.
- FSM states are IDLE, DATA, PARITY, STOP.
- IDLE: a sample of 0 is taken as the start bit. Go to DATA, clear the counter, latch msb_first into an internal order register. A sample of 1 stays in IDLE.
- DATA: each sample is shifted in.
  - LSB-first: the bit enters at the top and the register shifts right.
  - MSB-first: the bit enters at bit 0 and the register shifts left.
  - The counter increments on each sample. After sample DATA_W-1, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: sample the parity bit. Store perr = (XOR of the data bits) XOR sample, so even parity gives 0. Go to STOP.
- STOP: sample the stop bit, then return to IDLE in all cases.
  - Sample = 1: on the next clock edge, data_out is loaded with the assembled word, data_valid=1 and parity_err=perr (0 when PARITY_EN=0). Latency is exactly one cycle after the stop-bit sample cycle.
  - Sample = 0: data_out is unchanged, data_valid stays 0 and frame_err=1 on the next edge. The parity result of that frame is discarded.
- Pulse widths:
  - data_valid is always exactly one cycle.
  - With ERR_STICKY=0, parity_err and frame_err are one-cycle pulses.
  - With ERR_STICKY=1, they hold until the next frame that completes with a good stop bit, which then rewrites parity_err and clears frame_err.
- A start bit may be sampled on the very next bit_en after STOP; back-to-back frames need no gap cycle.
- msb_first changing mid-frame has no effect until the next start bit.
- ena deasserted mid-frame: the next edge goes to IDLE, the counter is cleared, and no valid or error pulse is produced. data_out and sticky flags are retained.
- rst_n asserted mid-frame: immediate return to reset values, and the partial word is lost.
- busy = (state != IDLE), driven combinationally from the state register.
- bit_en held high continuously is legal: one bit per clock.

Decomposition:
- Shared package ss_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - the counter width, computed as clog2(DATA_W);
  - IDLE_LEVEL=1'b1 and START_LEVEL=1'b0 constants.
- One sub-module, ss_bit_collector. It contains the DATA_W-bit direction-selectable shift register, the bit counter, a "last bit" flag and the running XOR for parity.
- The FSM and output registers stay in ss_frame_deser.

Test Plan:
- Test 1: DATA_W=8, PARITY_EN=1, bit_en=1 constant, msb_first=0. Send 0, then 1,0,1,0,0,1,0,1 (value 0xA5), parity 0, stop 1. Expect data_out=0xA5, one data_valid pulse one cycle after the stop sample, parity_err=0, frame_err=0.
- Test 2: same bits with msb_first=1. Expect data_out=0xA5 reversed=0xA5 from the palindromic pattern, so also send 0x3C bits 0,0,1,1,1,1,0,0 and expect data_out=0x3C.
- Test 3: 0xA5 frame with parity bit 1. Expect data_valid=1, data_out=0xA5, parity_err=1 for one cycle (ERR_STICKY=0).
- Test 4: 0x5A frame with stop bit 0. Expect frame_err pulse, no data_valid, data_out still holding the previous 0xA5. A following good 0x0F frame yields data_out=0x0F.
- Test 5: bit_en pulsing every 4th cycle, two back-to-back frames 0x81 then 0x7E with no idle bit. Expect two data_valid pulses with correct data, and busy never low between the frames' samples except for the single IDLE cycle span.
- Test 6: drop ena after the 4th data bit, then drop rst_n asynchronously mid-frame in a second run. Expect IDLE/busy=0 with no pulses in the first case, and all outputs 0 immediately in the second.
